// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM unified-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        IF_DROP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes seen by mem_arbiter.
// slave = arbiter view; master = pipeline plus memory view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_flush;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ack;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_be;
    logic [DATA_W-1:0]     dm_rdata;
    logic                  dm_ack;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    logic                  stall_if;
    logic                  stall_mem;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, if_flush,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/mem_arb_perf_cnt.sv
// Saturating event counter for arbitration conflicts (built only with MEM_ARB_PERF_EN).
module mem_arb_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (data over fetch) for the single-ported unified memory.
// Optional conflict counter port and logic enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_PERF_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arbiter_if.slave     bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_IF_BUSY = 2'(IF_BUSY);
    localparam logic [1:0] ST_DM_BUSY = 2'(DM_BUSY);
    localparam logic [1:0] ST_IF_DROP = 2'(IF_DROP);

    logic [1:0]        state;
    logic              dm_eff;
    logic              if_eff;
    logic [ADDR_W-1:0] grant_addr;

    // A requester whose ack is on the bus this cycle has already been served.
    always_comb begin
        dm_eff     = bus.dm_req & ~bus.dm_ack;
        if_eff     = bus.if_req & ~bus.if_ack & ~bus.if_flush;
        grant_addr = dm_eff ? bus.dm_addr : bus.if_addr;
    end

    assign bus.stall_if  = bus.if_req & ~bus.if_ack & ~bus.if_flush;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.if_ack    <= 1'b0;
            bus.dm_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // branch below sees the pre-edge values; acks default low so
            // they can only ever be one-cycle pulses.
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (dm_eff || if_eff) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= grant_addr;
                        bus.mem_we    <= dm_eff & bus.dm_we;
                        bus.mem_wdata <= dm_eff ? bus.dm_wdata : '0;
                        bus.mem_be    <= dm_eff ? bus.dm_be : {(DATA_W/8){1'b1}};
                        state         <= dm_eff ? ST_DM_BUSY : ST_IF_BUSY;
                    end
                end

                ST_DM_BUSY: begin
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        bus.dm_ack  <= 1'b1;
                        if (!bus.mem_we) begin
                            bus.dm_rdata <= bus.mem_rdata;
                        end
                        state <= ST_IDLE;
                    end
                end

                ST_IF_BUSY: begin
                    // A flush arriving with the completion still discards the fetch.
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        if (!bus.if_flush) begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_ack   <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (bus.if_flush) begin
                        state <= ST_IF_DROP;
                    end
                end

                ST_IF_DROP: begin
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic conflict;

    assign conflict = (state == ST_IDLE) & dm_eff & if_eff;

    mem_arb_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (conflict),
        .cnt   (conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_EN
    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
    logic [TB_CNT_W-1:0] conflict_cnt;
    int m_cnt = 0;
`endif

    mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
`ifdef MEM_ARB_PERF_EN
        ,
        .CNT_W  (TB_CNT_W)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave)
`ifdef MEM_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction record plus completion results.
    bit          m_active = 0, m_fetch = 0, m_drop = 0, m_we = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_be = '0;
    bit          m_if_ack = 0, m_dm_ack = 0;
    logic [31:0] m_if_rdata = '0, m_dm_rdata = '0;

    always @(posedge clk or negedge rst_n) begin
        bit ack_i, ack_d, want_d, want_i;
        if (!rst_n) begin
            m_active = 0; m_fetch = 0; m_drop = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_be = '0;
            m_if_ack = 0; m_dm_ack = 0; m_if_rdata = '0; m_dm_rdata = '0;
`ifdef MEM_ARB_PERF_EN
            m_cnt = 0;
`endif
        end else begin
            ack_i = m_if_ack;
            ack_d = m_dm_ack;
            m_if_ack = 0;
            m_dm_ack = 0;
            if (!m_active) begin
                want_d = bus.dm_req && !ack_d;
                want_i = bus.if_req && !ack_i && !bus.if_flush;
`ifdef MEM_ARB_PERF_EN
                if (want_d && want_i && m_cnt < CNT_MAX) m_cnt++;
`endif
                if (want_d) begin
                    m_active = 1; m_fetch = 0; m_drop = 0; m_we = bus.dm_we;
                    m_addr = bus.dm_addr; m_wdata = bus.dm_wdata; m_be = bus.dm_be;
                end else if (want_i) begin
                    m_active = 1; m_fetch = 1; m_drop = 0; m_we = 0;
                    m_addr = bus.if_addr;
                end
            end else begin
                if (m_fetch && bus.if_flush) m_drop = 1;
                if (bus.mem_ready) begin
                    m_active = 0;
                    if (m_fetch) begin
                        if (!m_drop) begin
                            m_if_ack = 1;
                            m_if_rdata = bus.mem_rdata;
                        end
                    end else begin
                        m_dm_ack = 1;
                        if (!m_we) m_dm_rdata = bus.mem_rdata;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("mem_req", bus.mem_req, m_active);
        if (m_active) begin
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_we", bus.mem_we, m_we);
            if (!m_fetch) begin
                check("mem_wdata", bus.mem_wdata, m_wdata);
                check("mem_be", bus.mem_be, m_be);
            end
        end
        check("if_ack", bus.if_ack, m_if_ack);
        check("dm_ack", bus.dm_ack, m_dm_ack);
        check("if_rdata", bus.if_rdata, m_if_rdata);
        check("dm_rdata", bus.dm_rdata, m_dm_rdata);
        check("stall_if", bus.stall_if, bus.if_req & ~m_if_ack & ~bus.if_flush);
        check("stall_mem", bus.stall_mem, bus.dm_req & ~m_dm_ack);
`ifdef MEM_ARB_PERF_EN
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: ready in the same cycle mem_req is seen high.
    task automatic respond();
        bus.mem_ready = bus.mem_req;
        bus.mem_rdata = bus.mem_addr ^ 32'h5A5A_0000;
    endtask

    task automatic conflict_pair(input logic [31:0] da, input logic [31:0] ia);
        int  n;
        bit  got;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = da; bus.dm_be = 4'hF;
        bus.if_req = 1; bus.if_addr = ia;
        n = 0; got = 0;
        while (!got && n < 20) begin tick(); respond(); got = bus.dm_ack; n++; end
        check("pair_dm_ack_seen", 32'(got), 1);
        tick(); respond(); bus.dm_req = 0;
        n = 0; got = bus.if_ack;
        while (!got && n < 20) begin tick(); respond(); got = bus.if_ack; n++; end
        check("pair_if_ack_seen", 32'(got), 1);
        tick(); respond(); bus.if_req = 0;
        tick(); bus.mem_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
        #1 rst_n = 1'b0;
        tick(); tick();
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_if_ack", bus.if_ack, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Lone fetch, one wait-free completion.
        bus.if_req = 1; bus.if_addr = 32'h100;
        #1 check("t1_stall_c0", bus.stall_if, 1);
        tick();
        check("t1_mem_req_c1", bus.mem_req, 1);
        check("t1_mem_addr_c1", bus.mem_addr, 32'h100);
        check("t1_stall_c1", bus.stall_if, 1);
        bus.mem_ready = 1; bus.mem_rdata = 32'h0050_0093;
        tick();
        bus.mem_ready = 0;
        check("t1_if_ack_c2", bus.if_ack, 1);
        check("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
        check("t1_stall_c2", bus.stall_if, 0);
        tick();
        bus.if_req = 0;
        check("t1_no_regrant", bus.mem_req, 0);
        tick();

        // Simultaneous load and fetch: data first.
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h200; bus.dm_be = 4'hF;
        bus.if_req = 1; bus.if_addr = 32'h104;
        tick();
        check("t2_mem_addr_c1", bus.mem_addr, 32'h200);
        bus.mem_ready = 1; bus.mem_rdata = 32'h1111_1111;
        tick();
        bus.mem_ready = 0;
        check("t2_dm_ack_c2", bus.dm_ack, 1);
        check("t2_dm_rdata", bus.dm_rdata, 32'h1111_1111);
        check("t2_if_ack_c2", bus.if_ack, 0);
        check("t2_stall_mem_c2", bus.stall_mem, 0);
        tick();
        bus.dm_req = 0;
        check("t2_mem_addr_c3", bus.mem_addr, 32'h104);
        check("t2_mem_req_c3", bus.mem_req, 1);
        bus.mem_ready = 1; bus.mem_rdata = 32'h2222_2222;
        tick();
        bus.mem_ready = 0;
        check("t2_if_ack_c4", bus.if_ack, 1);
        check("t2_if_rdata", bus.if_rdata, 32'h2222_2222);
`ifdef MEM_ARB_PERF_EN
        check("t2_conflict_cnt", 32'(conflict_cnt), 1);
`endif
        tick();
        bus.if_req = 0;
        tick();

        // Store with three wait cycles.
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40;
        bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'b0011;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("t3_mem_req_hold", bus.mem_req, 1);
            check("t3_mem_wdata_hold", bus.mem_wdata, 32'hDEAD_BEEF);
            check("t3_mem_be_hold", bus.mem_be, 4'b0011);
            check("t3_mem_we_hold", bus.mem_we, 1);
            check("t3_no_early_ack", bus.dm_ack, 0);
            if (c == 4) begin
                bus.mem_ready = 1; bus.mem_rdata = 32'hFFFF_0000;
            end
        end
        tick();
        bus.mem_ready = 0;
        check("t3_dm_ack", bus.dm_ack, 1);
        check("t3_dm_rdata_kept", bus.dm_rdata, 32'h1111_1111);
        tick();
        bus.dm_req = 0;
        check("t3_ack_pulse", bus.dm_ack, 0);
        tick();

        // Fetch flushed while in flight, then a new fetch.
        bus.if_req = 1; bus.if_addr = 32'h108;
        tick();
        check("t4_mem_req_c1", bus.mem_req, 1);
        bus.if_flush = 1;
        #1 check("t4_stall_flush", bus.stall_if, 0);
        tick();
        bus.if_flush = 0; bus.if_addr = 32'h300;
        check("t4_hold_addr", bus.mem_addr, 32'h108);
        bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.mem_ready = 0;
        check("t4_no_if_ack", bus.if_ack, 0);
        check("t4_if_rdata_kept", bus.if_rdata, 32'h2222_2222);
        check("t4_idle", bus.mem_req, 0);
        tick();
        check("t4_new_grant", bus.mem_req, 1);
        check("t4_new_addr", bus.mem_addr, 32'h300);
        bus.mem_ready = 1; bus.mem_rdata = 32'h3333_3333;
        tick();
        bus.mem_ready = 0;
        check("t4_new_ack", bus.if_ack, 1);
        check("t4_new_rdata", bus.if_rdata, 32'h3333_3333);
        tick();
        bus.if_req = 0;
        tick();

        // Asynchronous reset during a load.
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h280;
        tick();
        check("t5_busy", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_mem_req", bus.mem_req, 0);
        check("t5_rst_mem_addr", bus.mem_addr, 0);
        check("t5_rst_dm_ack", bus.dm_ack, 0);
        check("t5_rst_if_rdata", bus.if_rdata, 0);
        check("t5_rst_dm_rdata", bus.dm_rdata, 0);
        bus.dm_req = 0;
        @(negedge clk); rst_n = 1'b1;
        tick();
        bus.mem_ready = 1; bus.mem_rdata = 32'h4444_4444;
        tick();
        bus.mem_ready = 0;
        check("t5_late_ready_req", bus.mem_req, 0);
        check("t5_late_ready_ack", bus.dm_ack, 0);
        check("t5_late_ready_data", bus.dm_rdata, 0);
        tick();

        // Five conflicting pairs; the narrow counter saturates.
        for (int i = 0; i < 5; i++) begin
            conflict_pair(32'h400 + 32'(i * 4), 32'h500 + 32'(i * 4));
        end
        check("t6_last_if_rdata", bus.if_rdata, 32'h5A5A_0510);
        check("t6_last_dm_rdata", bus.dm_rdata, 32'h5A5A_0410);
`ifdef MEM_ARB_PERF_EN
        check("t6_cnt_saturated", 32'(conflict_cnt), 3);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing the single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RV32 pipeline. Grants one requester per transaction, holds the memory handshake until the memory reports ready, and returns registered read data. Produces per-stage stall signals that the hazard logic ORs into PC/IF-ID/ID-EX control.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width
- `CNT_W`, 16, conflict counter width (used only with `MEM_ARB_PERF_EN`)

Ports (`clk` is the single clock; `rst_n` is asynchronous, active-low):
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `if_req`  in  1  fetch request, held until `if_ack` or until aborted by `if_flush`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_flush`  in  1  branch-taken flush; discards the outstanding fetch
- `if_rdata`  out  DATA_W  fetched instruction, valid with `if_ack`
- `if_ack`  out  1  one-cycle fetch completion pulse
- `dm_req`  in  1  data request, held until `dm_ack`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_be`  in  DATA_W/8  byte enables
- `dm_rdata`  out  DATA_W  load data, valid with `dm_ack`
- `dm_ack`  out  1  one-cycle data completion pulse
- `mem_req`  out  1  memory request, registered
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completion, single cycle
- `stall_if`  out  1  `if_req & ~if_ack & ~if_flush`
- `stall_mem`  out  1  `dm_req & ~dm_ack`
- `conflict_cnt`  out  CNT_W  present only with `MEM_ARB_PERF_EN`

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY, IF_DROP.
- IDLE: effective requests are `dm_req & ~dm_ack` and `if_req & ~if_ack & ~if_flush` (a requester being acked this cycle is masked). Data wins over fetch (older instruction). The winner's fields are latched into the `mem_*` registers, `mem_req` is set, and the FSM goes to DM_BUSY or IF_BUSY.
- DM_BUSY / IF_BUSY: hold `mem_*` constant. On `mem_ready`, clear `mem_req`, capture `mem_rdata` into `dm_rdata`/`if_rdata` (loads and fetches only; stores leave `dm_rdata` unchanged), pulse the matching ack next cycle, and return to IDLE.
- `if_flush` in IF_BUSY goes to IF_DROP. IF_DROP waits for `mem_ready`, suppresses `if_ack`, leaves `if_rdata` unchanged, and returns to IDLE. `if_flush` in IDLE masks the fetch request for that cycle only.
- A requester must not withdraw a granted request. Withdrawing before grant is legal.
- Reset (asynchronous, any state): FSM goes to IDLE. `mem_req`, `if_ack`, `dm_ack`, all `mem_*` fields, `if_rdata`, `dm_rdata` and `conflict_cnt` go to 0. An in-flight memory transaction is abandoned.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: `mem_req`=1. Cycle k≥1: `mem_ready`. Cycle k+1: ack=1, rdata valid, FSM in IDLE.
- Minimum latency is 2 cycles (request to ack) with zero-wait memory.
- The next grant can be made in cycle k+1, so `mem_req` rises again in cycle k+2. Back-to-back throughput is one transaction per 2 cycles.
- When both requests arrive in the same IDLE cycle: data ack at k+1, fetch `mem_req` at k+2.
- `mem_ready` while `mem_req`=0 is ignored.

## Configuration
- `MEM_ARB_PERF_EN` defined: `conflict_cnt` port exists. It increments by 1 each IDLE cycle in which both effective requests are present, saturates at all-ones, and resets to 0.
- Not defined: no port and no counter logic. Arbitration behaviour is identical.

## Structure
- `mem_arb_pkg` holds the FSM state enum (IDLE/IF_BUSY/DM_BUSY/IF_DROP) and the default width constants.
- Sub-module `mem_arb_perf_cnt` is the saturating counter, instantiated only under `MEM_ARB_PERF_EN`.

## Test plan
- Lone fetch, `if_addr`=0x100, `mem_ready` in the cycle after `mem_req` rises, `mem_rdata`=0x00500093. Required: `if_ack` at cycle 2, `if_rdata`=0x00500093, `stall_if` high in cycles 0–1.
- Simultaneous load (`dm_addr`=0x200) and fetch (0x104), zero-wait memory. Required: `dm_ack` at cycle 2, `mem_addr`=0x104 at cycle 3, `if_ack` at cycle 4. With `MEM_ARB_PERF_EN`, `conflict_cnt`=1.
- Store with `dm_be`=4'b0011, `dm_wdata`=0xDEADBEEF, 3 wait cycles. Required: `mem_*` stable for 4 cycles, `dm_ack` one cycle after `mem_ready`, `dm_rdata` unchanged.
- Fetch in IF_BUSY, then `if_flush` pulsed before `mem_ready`. Required: no `if_ack`, FSM reaches IDLE after `mem_ready`, and a new fetch to 0x300 is then granted.
- `rst_n` low mid-DM_BUSY. Required: `mem_req`, acks and data outputs 0 immediately (asynchronously), FSM in IDLE. A late `mem_ready` after release is ignored.
- With `MEM_ARB_PERF_EN`, `CNT_W`=2 and 5 conflicts. Required: `conflict_cnt` stops at 3.
